aes_masked_io_ctrl: RTL and testbench

Host-side streaming front end for the byte-serial masked AES encryption unit. It accepts a 128-bit plaintext block over a start/done handshake and draws a fresh input/output mask pair per block from an LFSR. It serialises the block into the unit one byte per cycle, then collects the 16 unmasked ciphertext bytes back into a 128-bit register. It owns both the upstream feed of the unit and the downstream capture of its output.

---
 rtl/aes_masked_io_ctrl.sv | 143 ++++++++++++++
 tb/tb_aes_masked_io_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_masked_io_ctrl.sv
// Host-side streaming front end for the byte-serial masked AES unit: feeds a 128-bit block bytewise, captures the ciphertext.
// Optional mask refresh from a 16-bit LFSR is enabled by defining AES_MASK_REFRESH_EN; otherwise masks are tied to zero.
module aes_masked_io_ctrl #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [9:0]  TIMEOUT   = 10'd1023
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] pt,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [127:0] ct,
  output logic         valid_input,
  output logic [7:0]   data_in,
  output logic [7:0]   imask,
  output logic [7:0]   omask,
  input  logic         valid_output,
  input  logic [7:0]   data_out
);

  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [127:0]   r_sr;
  logic [119:0]   r_cap;
  logic [127:0]   r_ct;
  logic [3:0]     r_cnt;
  logic [9:0]     r_wcnt;
  logic           r_valid_in;
  logic [7:0]     r_data_in;
  logic           r_err;
  logic           r_done;
  logic           w_timeout;

  assign w_timeout = (r_wcnt == TIMEOUT - 10'd1);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_LOAD;
      S_LOAD:    if (r_cnt == 4'd15) w_next = S_WAIT;
      // valid_output takes precedence over a timeout on the same cycle
      S_WAIT: begin
        if (valid_output)   w_next = S_CAPTURE;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_CAPTURE: if (r_cnt == 4'd15) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr       <= '0;
      r_cap      <= '0;
      r_ct       <= '0;
      r_cnt      <= '0;
      r_wcnt     <= '0;
      r_valid_in <= 1'b0;
      r_data_in  <= '0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sr  <= pt;
            r_err <= 1'b0;
            r_cnt <= '0;
          end
        end
        S_LOAD: begin
          r_valid_in <= 1'b1;
          r_data_in  <= r_sr[127:120];
          r_sr       <= {r_sr[119:0], 8'h00};
          r_cnt      <= r_cnt + 4'd1;
          r_wcnt     <= '0;
        end
        S_WAIT: begin
          r_valid_in <= 1'b0;
          if (valid_output) begin
            r_cap <= {r_cap[111:0], data_out};
            r_cnt <= 4'd1;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_wcnt <= r_wcnt + 10'd1;
          end
        end
        // bytes collect in r_cap so ct only changes once a full block has arrived
        S_CAPTURE: begin
          r_cap <= {r_cap[111:0], data_out};
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) r_ct <= {r_cap, data_out};
        end
        default: ;
      endcase
    end
  end

`ifdef AES_MASK_REFRESH_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (reset)
      r_lfsr <= SEED;
    else if (r_state == S_IDLE && start)
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign imask = r_lfsr[7:0];
  assign omask = r_lfsr[15:8];
`else
  // unmasked baseline; the seed stays referenced so both builds share one parameter list
  assign {omask, imask} = SEED & 16'h0000;
`endif

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign err         = r_err;
  assign ct          = r_ct;
  assign valid_input = r_valid_in;
  assign data_in     = r_data_in;

endmodule

// File: tb/tb_aes_masked_io_ctrl.sv
// Bench for aes_masked_io_ctrl: behavioural AES unit model, LFSR mask model and ciphertext scoreboard.
// Mask expectations follow AES_MASK_REFRESH_EN the same way the design does.
module tb_aes_masked_io_ctrl;

  localparam logic [15:0] SEED = 16'hACE1;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] pt;
  logic         busy;
  logic         done;
  logic         err;
  logic [127:0] ct;
  logic         valid_input;
  logic [7:0]   data_in;
  logic [7:0]   imask;
  logic [7:0]   omask;
  logic         valid_output;
  logic [7:0]   data_out;

  always #5 clk = ~clk;

  aes_masked_io_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pt           (pt),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .ct           (ct),
    .valid_input  (valid_input),
    .data_in      (data_in),
    .imask        (imask),
    .omask        (omask),
    .valid_output (valid_output),
    .data_out     (data_out)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- AES-128 reference ----------------
  logic [7:0]   sbox_t [256];
  logic [127:0] key = 128'h000102030405060708090a0b0c0d0e0f;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] p, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ 8'(w[i/4] >> (24 - 8*(i%4)));
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int rr = 0; rr < 4; rr++)
        for (int c = 0; c < 4; c++) s[rr + 4*c] = t[rr + 4*((c + rr) % 4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ 8'(w[4*r + i/4] >> (24 - 8*(i%4)));
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- controller model ----------------
  logic [15:0]  m_lfsr;
  logic [127:0] m_ct;
  logic [127:0] exp_q[$];

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [15:0] exp_mask();
`ifdef AES_MASK_REFRESH_EN
    return m_lfsr;
`else
    return 16'h0000;
`endif
  endfunction

  // ---------------- AES unit model ----------------
  bit           u_respond = 1'b1;
  bit           u_glitch  = 1'b0;
  int           u_n;
  int           u_idx;
  int           u_delay;
  logic [127:0] u_pt;
  logic [127:0] u_ct;

  initial begin
    valid_output = 1'b0;
    data_out     = 8'h00;
    u_n   = 0;
    u_idx = -1;
    u_pt  = '0;
    forever begin
      @(negedge clk);
      valid_output = 1'b0;
      data_out     = 8'($urandom);
      if (reset) begin
        u_n   = 0;
        u_idx = -1;
      end else if (valid_input) begin
        u_pt = {u_pt[119:0], data_in};
        u_n++;
        if (u_glitch && u_n < 16) valid_output = 1'($urandom_range(0, 1));
        if (u_n == 16) begin
          u_n = 0;
          if (u_respond) begin
            u_ct    = aes_enc(u_pt, key);
            u_delay = $urandom_range(0, 20);
            u_idx   = 0;
          end
        end
      end else if (u_idx >= 0) begin
        if (u_delay > 0) u_delay--;
        else begin
          valid_output = (u_idx == 0);
          data_out     = u_ct[127-8*u_idx -: 8];
          u_idx++;
          if (u_idx == 16) u_idx = -1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_block(input logic [127:0] p, input logic [127:0] want,
                           input bit expect_timeout, input bit noise);
    logic [15:0]  mexp;
    logic [15:0]  mseen;
    logic [127:0] exp_ct;
    int           first_err;
    bit           got_done;
    @(negedge clk);
    start = 1'b1;
    pt    = p;
    m_lfsr = lfsr_step(m_lfsr);
    mexp   = exp_mask();
    mseen  = mexp;
    if (!expect_timeout) exp_q.push_back(want);
    @(negedge clk);
    start = noise;
    check("accept_busy", 128'(busy), 128'(1));
    check("err_cleared", 128'(err), 128'(0));
    check("vi_latency", 128'(valid_input), 128'(0));
    check("mask_load", 128'({omask, imask}), 128'(mexp));
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      start = noise;
      if ({omask, imask} !== mexp) mseen = {omask, imask};
      check("valid_input", 128'(valid_input), 128'(1));
      check("data_in", 128'(data_in), 128'(p[127-8*i -: 8]));
    end
    first_err = 0;
    got_done  = 1'b0;
    for (int k = 1; k <= 1200; k++) begin
      @(negedge clk);
      start = noise & busy;
      if ({omask, imask} !== mexp) mseen = {omask, imask};
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (err && first_err == 0) begin
        first_err = k;
        if (expect_timeout) break;
      end
    end
    start = 1'b0;
    check("mask_hold", 128'(mseen), 128'(mexp));
    if (expect_timeout) begin
      check("timeout_cycles", 128'(first_err), 128'(1023));
      check("timeout_idle", 128'(busy), 128'(0));
      check("timeout_ct_held", ct, m_ct);
      check("timeout_no_done", 128'(got_done), 128'(0));
    end else begin
      check("done_seen", 128'(got_done), 128'(1));
      if (exp_q.size() > 0) begin
        exp_ct = exp_q.pop_front();
        if (got_done) begin
          check("ct", ct, exp_ct);
          m_ct = exp_ct;
          check("done_idle", 128'(busy), 128'(0));
        end
      end
      @(negedge clk);
      check("done_width", 128'(done), 128'(0));
      check("no_restart", 128'(busy), 128'(0));
    end
  endtask

  task automatic reset_mid_load(input logic [127:0] p);
    @(negedge clk);
    start = 1'b1;
    pt    = p;
    m_lfsr = lfsr_step(m_lfsr);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) @(negedge clk);
    check("pre_reset_byte7", 128'(data_in), 128'(p[71:64]));
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    m_lfsr = SEED;
    m_ct   = '0;
    @(negedge clk);
    check("rst_valid_input", 128'(valid_input), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_mask", 128'({omask, imask}), 128'(exp_mask()));
    check("rst_ct", ct, m_ct);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- clock/reset and sequence ----------------
  initial begin
    logic [127:0] p;
    reset = 1'b1;
    start = 1'b0;
    pt    = '0;
    build_sbox();
    m_lfsr = SEED;
    m_ct   = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_done", 128'(done), 128'(0));
    check("reset_err", 128'(err), 128'(0));
    check("reset_valid_input", 128'(valid_input), 128'(0));
    check("reset_data_in", 128'(data_in), 128'(0));
    check("reset_ct", ct, 128'(0));
    check("reset_mask", 128'({omask, imask}), 128'(exp_mask()));

    run_block(128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, 1'b0);

    for (int b = 0; b < 3; b++) begin
      p = rand128();
      run_block(p, aes_enc(p, key), 1'b0, 1'b0);
    end

    u_respond = 1'b0;
    run_block(rand128(), '0, 1'b1, 1'b0);
    u_respond = 1'b1;
    check("err_sticky", 128'(err), 128'(1));
    p = rand128();
    run_block(p, aes_enc(p, key), 1'b0, 1'b0);

    reset_mid_load(rand128());
    p = rand128();
    run_block(p, aes_enc(p, key), 1'b0, 1'b0);

    u_glitch = 1'b1;
    p = rand128();
    run_block(p, aes_enc(p, key), 1'b0, 1'b1);
    u_glitch = 1'b0;

    for (int b = 0; b < 4; b++) begin
      p = rand128();
      run_block(p, aes_enc(p, key), 1'b0, ($urandom_range(0, 1) == 1));
    end

    run_block(128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
